// File: rtl/imem_loader.sv
// imem_loader: streams program bytes into a 128-word instruction memory.
// Bytes arrive on a valid/ready handshake and are packed little-endian into
// 32-bit words; each completed word is written at the running word_count.
// Instruction reads through addr/q are combinational and always available.
// Optional feature: define LOADER_CHECKSUM_EN to append a trailing XOR
// checksum byte to every non-empty load and flag a mismatch on err.

module imem_loader #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [7:0]   len,
   input  logic         byte_valid,
   input  logic [7:0]   byte_data,
   output logic         byte_ready,
   input  logic [6:0]   addr,
   output logic [N-1:0] q,
   output logic         busy,
   output logic         done,
   output logic [7:0]   word_count,
   output logic         err
);

   // Loader sequencing states; CHECK exists only when the checksum is built in.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
`ifdef LOADER_CHECKSUM_EN
      CHECK = 2'd2,
`endif
      DONE  = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [7:0]  effLen_q, effLen_d;
   logic [7:0]  wordCount_q, wordCount_d;
   logic [1:0]  byteIdx_q, byteIdx_d;
   logic [23:0] asm_q, asm_d;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  chkSum_q, chkSum_d;
   logic        err_q, err_d;
`endif

   logic [7:0]   lenSat;
   logic [7:0]   wordCountInc;
   logic         xferEn;
   logic         wrEn;
   logic [N-1:0] wrData;

   // Instruction store; starts cleared and is deliberately never reset so a
   // partially completed load survives a reset.
   logic [N-1:0] mem_q [128] = '{default: '0};

   // Requested length saturated to the memory depth.
   assign lenSat       = (len > 8'd128) ? 8'd128 : len;
   assign wordCountInc = wordCount_q + 8'd1;
   assign xferEn       = byte_valid && byte_ready;

   // The fourth byte of a word goes straight into the top lane of the write.
   assign wrData = {byte_data, asm_q};

   // Next-state, datapath updates and Moore outputs for the loader.
   always_comb begin
      state_d     = state_q;
      effLen_d    = effLen_q;
      wordCount_d = wordCount_q;
      byteIdx_d   = byteIdx_q;
      asm_d       = asm_q;
`ifdef LOADER_CHECKSUM_EN
      chkSum_d    = chkSum_q;
      err_d       = err_q;
`endif
      wrEn        = 1'b0;
      byte_ready  = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;

      case (state_q)
         IDLE, DONE: begin
            done = (state_q == DONE);
            if (start) begin
               effLen_d    = lenSat;
               wordCount_d = 8'd0;
               byteIdx_d   = 2'd0;
               asm_d       = 24'd0;
`ifdef LOADER_CHECKSUM_EN
               chkSum_d    = 8'd0;
               err_d       = 1'b0;
`endif
               state_d     = (lenSat == 8'd0) ? DONE : LOAD;
            end
         end

         LOAD: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            if (xferEn) begin
`ifdef LOADER_CHECKSUM_EN
               chkSum_d = chkSum_q ^ byte_data;
`endif
               byteIdx_d = byteIdx_q + 2'd1;
               case (byteIdx_q)
                  2'd0: asm_d[7:0]   = byte_data;
                  2'd1: asm_d[15:8]  = byte_data;
                  2'd2: asm_d[23:16] = byte_data;
                  default: begin
                     wrEn        = 1'b1;
                     wordCount_d = wordCountInc;
                     if (wordCountInc == effLen_q) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = CHECK;
`else
                        state_d = DONE;
`endif
                     end
                  end
               endcase
            end
         end

`ifdef LOADER_CHECKSUM_EN
         CHECK: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            if (xferEn) begin
               err_d   = (byte_data != chkSum_q);
               state_d = DONE;
            end
         end
`endif

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Control and datapath registers, cleared asynchronously by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         effLen_q    <= 8'd0;
         wordCount_q <= 8'd0;
         byteIdx_q   <= 2'd0;
         asm_q       <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
         chkSum_q    <= 8'd0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         effLen_q    <= effLen_d;
         wordCount_q <= wordCount_d;
         byteIdx_q   <= byteIdx_d;
         asm_q       <= asm_d;
`ifdef LOADER_CHECKSUM_EN
         chkSum_q    <= chkSum_d;
         err_q       <= err_d;
`endif
      end
   end

   // Memory write port; the new word is visible on q only after this edge.
   always_ff @(posedge clk) begin
      if (wrEn) begin
         mem_q[wordCount_q[6:0]] <= wrData;
      end
   end

   assign q          = mem_q[addr];
   assign word_count = wordCount_q;

`ifdef LOADER_CHECKSUM_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter N, default 32, meaning instruction word width in bits; only N = 32 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, reset that is asynchronous and active-low (0 = reset).
REQ-004 SHALL have port start, input, 1, a one-cycle request to begin a load.
REQ-005 SHALL have port len, input, 8, the number of words to load, sampled with start.
REQ-006 SHALL have port byte_valid, input, 1, meaning byte_data holds a valid byte.
REQ-007 SHALL have port byte_data, input, 8, the incoming program byte.
REQ-008 SHALL have port byte_ready, output, 1, meaning the block accepts a byte this cycle.
REQ-009 SHALL have port addr, input, 7, the instruction read address.
REQ-010 SHALL have port q, output, N, the instruction word at addr.
REQ-011 SHALL have port busy, output, 1, meaning a load is in progress.
REQ-012 SHALL have port done, output, 1, meaning the last load completed.
REQ-013 SHALL have port word_count, output, 8, the number of words written in the current or last load.
REQ-014 SHALL have port err, output, 1, the checksum mismatch flag (see Configuration).

Function
REQ-015 SHALL hold a 128 x N memory that is zero at power-up; q SHALL be combinational: q = mem[addr] in every state.
REQ-016 SHALL use the FSM states IDLE, LOAD, CHECK and DONE; the reset state SHALL be IDLE.
REQ-017 In IDLE or DONE, start=1 SHALL capture the effective length, clear word_count, the byte index, the checksum and err, and go to LOAD; if the effective length is 0, it SHALL go directly to DONE.
REQ-018 Effective length SHALL be len when len <= 128, and 128 when len > 128 (saturation).
REQ-019 start SHALL be ignored while in LOAD or CHECK.
REQ-020 byte_ready SHALL be 1 exactly in LOAD and CHECK; a byte transfers when byte_valid && byte_ready.
REQ-021 Bytes SHALL be assembled little-endian; transfers 0..3 of a word map to bits [7:0], [15:8], [23:16], [31:24].
REQ-022 On the 4th byte of a word, the block SHALL write the assembled word to mem[word_count[6:0]] at that same clock edge and increment word_count.
REQ-023 A read of the address being written SHALL return the new word from the cycle after the write edge; there is no bypass.
REQ-024 After the write that makes word_count equal the effective length, the block SHALL go to CHECK if LOADER_CHECKSUM_EN is defined, otherwise to DONE.
REQ-025 Cycles with byte_valid=0 SHALL stall without changing state; there is no timeout.
REQ-026 busy SHALL be 1 in LOAD and CHECK, and done SHALL be 1 in DONE; done stays high until the next accepted start.
REQ-027 word_count SHALL hold its final value in DONE.

Reset
REQ-028 Asserting reset=0 SHALL immediately force the following values: state IDLE, byte_ready 0, busy 0, done 0, err 0, word_count 0, byte index 0, checksum 0.
REQ-029 Reset SHALL NOT alter memory contents; words already written by an interrupted load SHALL remain.

Configuration
REQ-030 With macro LOADER_CHECKSUM_EN defined, the block SHALL keep a running 8-bit XOR of all data bytes.
REQ-031 With LOADER_CHECKSUM_EN defined, CHECK SHALL accept one further byte and compare it to the running XOR.
REQ-032 With LOADER_CHECKSUM_EN defined, on a checksum mismatch err SHALL be set to 1 entering DONE, and SHALL hold until the next start.
REQ-033 With LOADER_CHECKSUM_EN defined, a zero-length load SHALL skip CHECK.
REQ-034 Without LOADER_CHECKSUM_EN, the CHECK state and XOR logic SHALL be absent and err SHALL be tied to 0.

Verification
REQ-035 Bench SHALL cover: start, len=2, bytes 01 00 00 F8 02 80 00 F8 -> mem[0]=F8000001, mem[1]=F8008002, word_count=2, done=1, busy=0.
REQ-036 Bench SHALL cover: byte_valid deasserted for 5 cycles mid-word -> no write, state LOAD held, final word still correct.
REQ-037 Bench SHALL cover: len=200 -> 128 words written to addr 0..127, word_count=128, done=1.
REQ-038 Bench SHALL cover: len=0 -> DONE on the next cycle, byte_ready never 1, memory unchanged.
REQ-039 Bench SHALL cover: reset=0 after 6 bytes of len=3 -> IDLE and outputs cleared, mem[0] retains word 0, mem[1] unchanged.
REQ-040 Bench SHALL cover, with LOADER_CHECKSUM_EN: len=1, bytes 01 02 03 04 then checksum 04 -> err=0; same stream with checksum 05 -> err=1.
